// File: rtl/cordic_vec_iq.sv
// rtl/cordic_vec_iq.sv - fully pipelined vectoring CORDIC, I/Q to phase and magnitude
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (valid bits and outputs only)
//   ce         pipeline advance enable; everything holds when low
//   in_valid   qualifies IS/QS
//   IS, QS     signed IW-bit in-phase / quadrature samples
//   out_valid  qualifies angle/abs
//   angle      signed AW-bit phase, -2^(AW-1) = -180 deg
//   abs        unsigned IW+2-bit magnitude
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   -> abs scaled by 1/K through one extra registered multiply stage
//   undefined -> abs is the raw CORDIC x (gain ~1.6468), no multiplier
module cordic_vec_iq #(
    parameter int IW     = 30,
    parameter int AW     = 32,
    parameter int STAGES = AW - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] IS,
    input  logic signed [IW-1:0] QS,
    output logic                 out_valid,
    output logic signed [AW-1:0] angle,
    output logic        [IW+1:0] abs
);
    // IW+2 integer bits cover the CORDIC growth of a full-scale corner vector,
    // plus 2 guard LSBs to soak up shift truncation.
    localparam int W = IW + 4;

    // atan(2^-i) scaled so that 2^32 = 360 deg.
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  atan32 = 32'd536870912;
            1:  atan32 = 32'd316933406;
            2:  atan32 = 32'd167458907;
            3:  atan32 = 32'd85004756;
            4:  atan32 = 32'd42667331;
            5:  atan32 = 32'd21354465;
            6:  atan32 = 32'd10679838;
            7:  atan32 = 32'd5340245;
            8:  atan32 = 32'd2670163;
            9:  atan32 = 32'd1335087;
            10: atan32 = 32'd667544;
            11: atan32 = 32'd333772;
            12: atan32 = 32'd166886;
            13: atan32 = 32'd83443;
            14: atan32 = 32'd41722;
            15: atan32 = 32'd20861;
            16: atan32 = 32'd10430;
            17: atan32 = 32'd5215;
            18: atan32 = 32'd2608;
            19: atan32 = 32'd1304;
            20: atan32 = 32'd652;
            21: atan32 = 32'd326;
            22: atan32 = 32'd163;
            23: atan32 = 32'd81;
            24: atan32 = 32'd41;
            25: atan32 = 32'd20;
            26: atan32 = 32'd10;
            27: atan32 = 32'd5;
            28: atan32 = 32'd3;
            29: atan32 = 32'd1;
            30: atan32 = 32'd1;
            default: atan32 = 32'd0;
        endcase
    endfunction

    // Rescale the 32-bit table to AW bits with round-half-up.
    function automatic logic [AW-1:0] atan_tab(input int i);
        logic [63:0] r;
        r = {32'd0, atan32(i)};
        r = (r + ((64'd1 << (32 - AW)) >> 1)) >> (32 - AW);
        return r[AW-1:0];
    endfunction

    logic signed [W-1:0]  x_q [0:STAGES];
    logic signed [W-1:0]  y_q [0:STAGES];
    logic        [AW-1:0] z_q [0:STAGES];
    logic        [STAGES:0] v_q;
    logic        [STAGES:0] zf_q;  // sample was exactly (0,0)

    logic signed [W-1:0] is_ext;
    logic signed [W-1:0] qs_ext;
    assign is_ext = {{2{IS[IW-1]}}, IS, 2'b00};
    assign qs_ext = {{2{QS[IW-1]}}, QS, 2'b00};

    always_ff @(posedge clk) begin
        if (ce) begin
            zf_q <= {zf_q[STAGES-1:0], (IS == '0) && (QS == '0)};
            // Left half-plane: rotate by 180 deg. +180 and -180 share the
            // same AW-bit pattern, so the seed does not depend on Q.
            if (IS[IW-1]) begin
                x_q[0] <= -is_ext;
                y_q[0] <= -qs_ext;
                z_q[0] <= {1'b1, {(AW-1){1'b0}}};
            end else begin
                x_q[0] <= is_ext;
                y_q[0] <= qs_ext;
                z_q[0] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (!y_q[k-1][W-1]) begin
                    x_q[k] <= x_q[k-1] + (y_q[k-1] >>> (k - 1));
                    y_q[k] <= y_q[k-1] - (x_q[k-1] >>> (k - 1));
                    z_q[k] <= z_q[k-1] + atan_tab(k - 1);
                end else begin
                    x_q[k] <= x_q[k-1] - (y_q[k-1] >>> (k - 1));
                    y_q[k] <= y_q[k-1] + (x_q[k-1] >>> (k - 1));
                    z_q[k] <= z_q[k-1] - atan_tab(k - 1);
                end
            end
        end
    end

    logic          fin_v;
    logic          fin_zf;
    logic [AW-1:0] fin_z;
    logic [IW+1:0] abs_d;

`ifdef CORDIC_GAIN_COMP_EN
    // round(2^32 / K)
    localparam logic [31:0]   INV_K  = 32'd2608131496;
    localparam logic [W+31:0] P_HALF = (W + 32)'(1) << 33;

    logic [W+31:0] p_q;
    logic [AW-1:0] pz_q;
    logic          pzf_q;
    logic          pv_q;
    logic [W+31:0] p_rnd;
    logic          unused_bits;

    // x is never negative after the pre-rotation, so an unsigned multiply is safe.
    always_ff @(posedge clk) begin
        if (ce) begin
            p_q   <= (W + 32)'($unsigned(x_q[STAGES])) * (W + 32)'(INV_K);
            pz_q  <= z_q[STAGES];
            pzf_q <= zf_q[STAGES];
        end
    end

    assign p_rnd       = p_q + P_HALF;
    assign abs_d       = p_rnd[IW+35:34];
    assign fin_v       = pv_q;
    assign fin_z       = pz_q;
    assign fin_zf      = pzf_q;
    assign unused_bits = ^p_rnd[33:0];
`else
    logic [W-1:0] x_rnd;
    logic         unused_bits;

    assign x_rnd       = $unsigned(x_q[STAGES]) + W'(2);
    assign abs_d       = x_rnd[W-1:2];
    assign fin_v       = v_q[STAGES];
    assign fin_z       = z_q[STAGES];
    assign fin_zf      = zf_q[STAGES];
    assign unused_bits = ^x_rnd[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            pv_q      <= 1'b0;
`endif
            out_valid <= 1'b0;
            angle     <= '0;
            abs       <= '0;
        end else if (ce) begin
            v_q       <= {v_q[STAGES-1:0], in_valid};
`ifdef CORDIC_GAIN_COMP_EN
            pv_q      <= v_q[STAGES];
`endif
            out_valid <= fin_v;
            if (fin_v) begin
                // (0,0) would otherwise report the sum of all micro-rotations.
                angle <= fin_zf ? '0 : $signed(fin_z);
                abs   <= abs_d;
            end
        end
    end
endmodule

// File: doc/cordic_vec_iq.md
CORDIC_VEC_IQ -- requirements
Module: cordic_vec_iq

Interface
REQ-001 Parameter IW, default 30: signed I/Q input width, legal range 8..30.
REQ-002 Parameter AW, default 32: signed angle output width, legal range 16..32.
REQ-003 Parameter STAGES, default AW-1: number of CORDIC micro-rotation stages, legal range 8..AW-1.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 ce  in  1  pipeline advance enable.
REQ-007 in_valid  in  1  IS/QS qualifier.
REQ-008 IS  in  IW  signed in-phase sample.
REQ-009 QS  in  IW  signed quadrature sample.
REQ-010 out_valid  out  1  angle/abs qualifier.
REQ-011 angle  out  AW  signed phase; full scale -2^(AW-1) = -180 deg, so LSB = 180/2^(AW-1) deg.
REQ-012 abs  out  IW+2  unsigned magnitude.

Function
REQ-013 The block SHALL be a fully pipelined vectoring CORDIC that accepts one sample per enabled cycle.
REQ-014 Stage 0 SHALL pre-rotate into the right half-plane: if I<0, negate (I,Q) into IW+2-bit registers and seed phase +/-2^(AW-1), with the sign taken from Q (Q=0 gives -2^(AW-1)).
REQ-015 Stage k, for k=1..STAGES, SHALL apply the micro-rotation with shift k-1 and atan(2^-(k-1)) from a constant table rounded to AW bits, choosing direction from the sign of y.
REQ-016 Internal x/y SHALL carry IW+2 integer bits plus 2 guard LSBs, with no overflow for any input pair, including (-2^(IW-1), -2^(IW-1)).
REQ-017 Latency SHALL be LAT = STAGES+2 enabled cycles with the compensation feature compiled out, and STAGES+3 with it compiled in; defaults give 33 and 34.
REQ-018 When ce=0, every pipeline register, out_valid, angle and abs SHALL hold, and in_valid/IS/QS SHALL be ignored.
REQ-019 A valid bit SHALL travel with each sample; out_valid SHALL be 1 exactly LAT enabled cycles after in_valid=1 was sampled with ce=1.
REQ-020 angle and abs SHALL be registered outputs and SHALL change only on enabled cycles.
REQ-021 Input (0,0) SHALL produce angle=0 and abs=0 exactly.
REQ-022 For the -180 deg boundary (Q=0, I<0), any result within +/-16 LSB modulo 2^AW SHALL be accepted; the angle SHALL wrap and never saturate.
REQ-023 For default parameters, accuracy SHALL be |angle error| <= 16 LSB and |abs error| <= 16 LSB versus the double-precision atan2/hypot result.

Reset
REQ-024 While rst_n=0, all valid bits and out_valid SHALL be 0, and angle and abs SHALL be 0, independently of clk.
REQ-025 Data registers other than the outputs MAY remain unreset.
REQ-026 After rst_n deasserts, no out_valid=1 SHALL appear before LAT enabled cycles following the first accepted sample.
REQ-027 Reset mid-stream SHALL discard all in-flight samples.

Configuration
REQ-028 The macro CORDIC_GAIN_COMP_EN SHALL select magnitude gain compensation.
REQ-029 With CORDIC_GAIN_COMP_EN defined, abs SHALL equal round(x_final * 1/K), where K = prod(sqrt(1+2^-2i)), using one extra registered multiply stage; abs[IW+1] SHALL then always be 0.
REQ-030 Without CORDIC_GAIN_COMP_EN, abs SHALL equal the raw x_final, rounded after removal of the guard bits (approximately 1.6468*|v|), with no multiplier present.

Verification
REQ-031 Defaults, comp on, ce=1, single sample I=2^28, Q=0 -> out_valid pulses 34 cycles later; angle=0 +/-16; abs=268435456 +/-16.
REQ-032 I=0, Q=2^28 -> angle=0x40000000 +/-16; abs=268435456 +/-16; I=0, Q=-2^28 -> angle=0xC0000000 +/-16.
REQ-033 I=Q=-2^29 -> angle=0xA0000000 +/-16; abs=759250125 +/-16; no overflow.
REQ-034 Stream of 10 samples with ce=0 for 5 cycles mid-stream -> outputs and out_valid frozen during the stall; every result still emerges after 34 enabled cycles, in order, with no duplicates.
REQ-035 Assert rst_n=0 for 1 cycle while 20 samples are in flight -> out_valid=0, angle=0 and abs=0 immediately; no stale out_valid=1 after release.
REQ-036 1024 random points back-to-back, plus (0,0) and I=-2^28, Q=0, rerun once with comp off -> one result per cycle; all within REQ-023 or REQ-022; comp-off abs within +/-32 LSB of 1.6468*|v|.
